// File: rtl/dffram_wb_adapter_pkg.sv
// Shared definitions for the DFFRAM Wishbone front-end and the RAM wrapper.
//   state_t            : adapter FSM state encoding (IDLE/RESP)
//   DEFAULT_BASE_ADDR  : default byte base address of the RAM window
//   a_width()          : RAM word-address width for a given column count
package dffram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    function automatic int unsigned a_width(input int unsigned cols);
        return 8 + $clog2(cols);
    endfunction

endpackage

// File: rtl/dffram_wb_adapter_if.sv
// Wishbone-classic slave bus bundle for dffram_wb_adapter.
//   wb_cyc_i/wb_stb_i/wb_we_i : cycle, strobe, write enable
//   wb_sel_i                  : byte selects
//   wb_adr_i/wb_dat_i         : byte address, write data
//   wb_dat_o/wb_ack_o/wb_err_o: read data, acknowledge, error
interface dffram_wb_adapter_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/dffram_wb_adapter.sv
// Wishbone-classic slave adapter in front of one DFFRAM macro.
// Converts single bus cycles into RAM EN/WE/A/Di strobes and returns the
// RAM's registered Do during the single-cycle response.
// Ports:
//   CLK, RSTn : shared clock, asynchronous active-low reset
//   wb        : Wishbone slave bundle (dffram_wb_adapter_if.slave)
//   ram_en, ram_we, ram_a, ram_di : strobes to the RAM
//   ram_do    : registered read data from the RAM
// Optional build macro DFFRAM_WB_ERR_EN: invalid addresses answer with
// wb_err_o instead of wb_ack_o. Without it wb_err_o is tied low.
module dffram_wb_adapter
    import dffram_pkg::*;
#(
    parameter int unsigned COLS      = 1,
    parameter int unsigned A_WIDTH   = a_width(COLS),
    parameter int unsigned DEPTH     = 128 * COLS,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic               CLK,
    input  logic               RSTn,
    dffram_wb_adapter_if.slave wb,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [A_WIDTH-1:0] ram_a,
    output logic [31:0]        ram_di,
    input  logic [31:0]        ram_do
);

    // Window covers 4 * 2^A_WIDTH bytes; everything above it must match BASE_ADDR.
    localparam logic [31:0] WIN_MASK = ~((32'd4 << A_WIDTH) - 32'd1);

    state_t             state;
    logic               was_read;
    logic               was_valid;
    logic               ack_q;
    logic               hit;
    logic               valid;
    logic               req;
    logic [A_WIDTH-1:0] word;

    always_comb begin
        hit   = (wb.wb_adr_i & WIN_MASK) == BASE_ADDR;
        word  = wb.wb_adr_i[A_WIDTH+1:2];
        valid = hit && (32'(word) < DEPTH);
        req   = wb.wb_cyc_i && wb.wb_stb_i && (state == IDLE);
    end

    // RAM strobes are gated by RSTn so the macro is never enabled in reset.
    always_comb begin
        ram_en = req && valid && RSTn;
        ram_we = (req && valid && wb.wb_we_i && RSTn) ? wb.wb_sel_i : 4'b0;
        ram_a  = word;
        ram_di = wb.wb_dat_i;
    end

`ifdef DFFRAM_WB_ERR_EN
    logic err_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            was_read  <= 1'b0;
            was_valid <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state     <= RESP;
                    was_read  <= !wb.wb_we_i;
                    was_valid <= valid;
                    ack_q     <= valid;
                    err_q     <= !valid;
                end
                RESP: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb.wb_err_o = err_q;
`else
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            was_read  <= 1'b0;
            was_valid <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state     <= RESP;
                    was_read  <= !wb.wb_we_i;
                    was_valid <= valid;
                    ack_q     <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb.wb_err_o = 1'b0;
`endif

    assign wb.wb_ack_o = ack_q;
    // RAM Do is valid only in the response cycle of a read; zero otherwise.
    assign wb.wb_dat_o = (ack_q && was_read && was_valid) ? ram_do : '0;

endmodule

// File: tb/tb_dffram_wb_adapter.sv
// Self-checking bench for dffram_wb_adapter with a behavioural RAM and a
// word-array reference model of the memory contents.
module tb_dffram_wb_adapter;
    import dffram_pkg::*;

    localparam logic [31:0] BASE      = 32'h3000_0000;
    localparam int unsigned WIN_BYTES = 1024;
    localparam int unsigned NWORDS    = 128;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do = '0;

    logic [31:0] ram_mem [NWORDS] = '{default: '0};
    logic [31:0] ref_mem [NWORDS] = '{default: '0};

    int checks = 0;
    int errors = 0;

    dffram_wb_adapter_if wb ();

    dffram_wb_adapter #(
        .COLS      (1),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .wb     (wb.slave),
        .ram_en (ram_en),
        .ram_we (ram_we),
        .ram_a  (ram_a),
        .ram_di (ram_di),
        .ram_do (ram_do)
    );

    always #5 CLK = ~CLK;

    // DFFRAM behaviour: Do registers the addressed word when enabled, clears otherwise.
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= ram_mem[ram_a[6:0]];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_a[6:0]][8*b +: 8] <= ram_di[8*b +: 8];
        end else begin
            ram_do <= '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete single transfer; expectations come from address arithmetic
    // on the window and the reference word array.
    task automatic bus_op(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input string tag);
        logic        valid;
        int unsigned word;
        logic [31:0] exp_dat;
        logic        exp_ack;
        logic        exp_err;
        word  = 0;
        valid = 1'b0;
        if (adr >= BASE && adr - BASE < WIN_BYTES) begin
            word  = (adr - BASE) / 4;
            valid = word < NWORDS;
        end
`ifdef DFFRAM_WB_ERR_EN
        exp_ack = valid;
        exp_err = !valid;
`else
        exp_ack = 1'b1;
        exp_err = 1'b0;
`endif
        exp_dat = (!we && valid) ? ref_mem[word] : 32'h0;

        @(negedge CLK);
        chk({tag, "_idle_ack"}, 32'(wb.wb_ack_o), 32'd0);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr;  wb.wb_sel_i = sel;  wb.wb_dat_i = dat;
        #1;
        chk({tag, "_ram_en"}, 32'(ram_en), 32'(valid));
        chk({tag, "_ram_we"}, 32'(ram_we), (valid && we) ? 32'(sel) : 32'd0);
        if (valid) chk({tag, "_ram_a"}, 32'(ram_a), word);
        @(posedge CLK);
        #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        @(negedge CLK);
        chk({tag, "_ack"}, 32'(wb.wb_ack_o), 32'(exp_ack));
        chk({tag, "_err"}, 32'(wb.wb_err_o), 32'(exp_err));
        chk({tag, "_dat"}, wb.wb_dat_o, exp_dat);
        if (we && valid)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[word][8*b +: 8] = dat[8*b +: 8];
    endtask

    initial begin
        RSTn = 1'b0;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_sel_i = 4'hF; wb.wb_adr_i = BASE; wb.wb_dat_i = 32'h1234_5678;
        #2;
        chk("rst_ack", 32'(wb.wb_ack_o), 32'd0);
        chk("rst_err", 32'(wb.wb_err_o), 32'd0);
        chk("rst_dat", wb.wb_dat_o, 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        @(negedge CLK); @(negedge CLK);
        RSTn = 1'b1;

        // Full write, partial byte overwrite, read-backs.
        bus_op(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, "wr_full");
        bus_op(1'b0, BASE + 32'h10, 4'h0, 32'h0,         "rd_full");
        bus_op(1'b1, BASE + 32'h10, 4'b0010, 32'h0000_AA00, "wr_byte1");
        bus_op(1'b0, BASE + 32'h13, 4'h0, 32'h0,         "rd_byte1");
        chk("model_word4", ref_mem[4], 32'hDEAD_AAEF);
        bus_op(1'b1, BASE + 32'h10, 4'h0, 32'hFFFF_FFFF, "wr_sel0");
        bus_op(1'b0, BASE + 32'h10, 4'hF, 32'h0,         "rd_sel0");

        // Invalid word inside the window and addresses outside it.
        bus_op(1'b0, BASE + 32'h200, 4'hF, 32'h0,         "rd_word128");
        bus_op(1'b1, BASE + 32'h3FC, 4'hF, 32'h5555_5555, "wr_word255");
        bus_op(1'b1, BASE + 32'h0001_0010, 4'hF, 32'h1111_1111, "wr_outside");
        bus_op(1'b1, BASE - 32'h4, 4'hF, 32'h2222_2222,   "wr_below");
        bus_op(1'b0, BASE + 32'h10, 4'hF, 32'h0,          "rd_unchanged");
        bus_op(1'b0, BASE + 32'h400, 4'hF, 32'h0,         "rd_abovewin");

        // Back-to-back reads with strobe held high.
        for (int i = 0; i < 4; i++)
            bus_op(1'b1, BASE + 32'(4 * i), 4'hF, $urandom, "b2b_fill");
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_idle_ack", 32'(wb.wb_ack_o), 32'd0);
            wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
            wb.wb_sel_i = 4'hF; wb.wb_adr_i = BASE + 32'(4 * i);
            #1;
            chk("b2b_ram_en", 32'(ram_en), 32'd1);
            @(posedge CLK);
            @(negedge CLK);
            chk("b2b_ack", 32'(wb.wb_ack_o), 32'd1);
            chk("b2b_dat", wb.wb_dat_o, ref_mem[i]);
            chk("b2b_no_reaccept", 32'(ram_en), 32'd0);
            @(posedge CLK);
            @(negedge CLK);
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;

        // Reset pulsed in the response cycle.
        @(negedge CLK);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = BASE + 32'h10;
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid_ack_before", 32'(wb.wb_ack_o), 32'd1);
        RSTn = 1'b0;
        #1;
        chk("rstmid_ack", 32'(wb.wb_ack_o), 32'd0);
        chk("rstmid_dat", wb.wb_dat_o, 32'd0);
        chk("rstmid_ram_en", 32'(ram_en), 32'd0);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        bus_op(1'b0, BASE + 32'h10, 4'hF, 32'h0, "rd_after_rst");

        // Randomized transfers against the reference array.
        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            logic [31:0] adr;
            kind = $urandom_range(0, 9);
            if (kind < 7)
                adr = BASE + 32'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(0, 3));
            else if (kind < 8)
                adr = BASE + 32'($urandom_range(NWORDS, 255) * 4);
            else
                adr = BASE + 32'h1000 + 32'($urandom_range(0, 32'h00FF_FFFF));
            bus_op(1'($urandom_range(0, 1)), adr, 4'($urandom), $urandom, "rand");
        end
        for (int i = 0; i < 8; i++)
            bus_op(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, "rand_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
